// File: rtl/reorder_buffer_pkg.sv
// Shared widths, op encodings and entry states
// for the reorder buffer and its query helper.
package reorder_buffer_pkg;

  localparam int OP_WIDTH         = 7;
  localparam int VAL_WIDTH        = 32;
  localparam int ADDR_WIDTH       = 32;
  localparam int ROB_ID_WIDTH_DEF = 3;
  localparam int ROB_SIZE_DEF     = 8;

  localparam logic [OP_WIDTH-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_WIDTH-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_WIDTH-1:0] OP_ALU    = 7'b0110011;
  localparam logic [OP_WIDTH-1:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ISSUED = 2'd1,
    ST_DONE   = 2'd2
  } rob_state_e;

  function automatic logic is_store(
    input logic [OP_WIDTH-1:0] op
  );
    return op == OP_STORE;
  endfunction

endpackage

// File: rtl/reorder_buffer_query.sv
// Operand lookup for one reservation-station port:
// stored result first, then same-cycle CDB bypass.
module reorder_buffer_query
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE     = ROB_SIZE_DEF,
  parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF
) (
  input  logic [ROB_ID_WIDTH:0]               query_lab,
  input  logic [ROB_SIZE-1:0]                 done,
  input  logic [ROB_SIZE-1:0][VAL_WIDTH-1:0]  vals,
  input  logic                                cdb_ready,
  input  logic [ROB_ID_WIDTH:0]               rs_lab,
  input  logic [VAL_WIDTH-1:0]                rs_val,
  input  logic [ROB_ID_WIDTH:0]               lsb_lab,
  input  logic [VAL_WIDTH-1:0]                lsb_val,
  output logic                                ready,
  output logic [VAL_WIDTH-1:0]                res
);

  logic [ROB_ID_WIDTH-1:0] idx;
  logic                    no_dep;
  logic                    rs_hit;
  logic                    lsb_hit;

  assign idx     = query_lab[ROB_ID_WIDTH-1:0]
                 - ROB_ID_WIDTH'(1);
  assign no_dep  = query_lab == '0;
  assign rs_hit  = cdb_ready && rs_lab == query_lab;
  assign lsb_hit = cdb_ready && lsb_lab == query_lab;

  // tag 0 means no dependency; else storage, then bypass
  always_comb begin
    ready = 1'b0;
    res   = '0;
    if (no_dep) begin
      ready = 1'b1;
    end else if (done[idx]) begin
      ready = 1'b1;
      res   = vals[idx];
    end else if (rs_hit) begin
      ready = 1'b1;
      res   = rs_val;
    end else if (lsb_hit) begin
      ready = 1'b1;
      res   = lsb_val;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with CDB completion,
// operand bypass and jump-triggered flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE     = ROB_SIZE_DEF,
  parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    dec2rob_en,
  input  logic [OP_WIDTH-1:0]     dec_type,
  input  logic [4:0]              dec_rd,
  input  logic [ADDR_WIDTH-1:0]   dec_pc,
  output logic                    isFull,
  output logic [ROB_ID_WIDTH:0]   newTag,
  input  logic [ROB_ID_WIDTH:0]   query_lab1,
  input  logic [ROB_ID_WIDTH:0]   query_lab2,
  output logic                    ready1,
  output logic                    ready2,
  output logic [VAL_WIDTH-1:0]    res1,
  output logic [VAL_WIDTH-1:0]    res2,
  input  logic                    cdbReady,
  input  logic [ROB_ID_WIDTH:0]   rs_cdb2lab,
  input  logic [VAL_WIDTH-1:0]    rs_cdb2val,
  input  logic                    rs_cdb2jump,
  input  logic [ADDR_WIDTH-1:0]   rs_cdb2target,
  input  logic [ROB_ID_WIDTH:0]   lsb_cdb2lab,
  input  logic [VAL_WIDTH-1:0]    lsb_cdb2val,
  output logic                    commit_en,
  output logic [ROB_ID_WIDTH:0]   commit_lab,
  output logic [4:0]              commit_rd,
  output logic [VAL_WIDTH-1:0]    commit_val,
  output logic                    commit_store,
  output logic                    flush,
  output logic [ADDR_WIDTH-1:0]   flush_pc
);

  localparam int TW = ROB_ID_WIDTH + 1;

  logic [ROB_ID_WIDTH-1:0]             head;
  logic [ROB_ID_WIDTH-1:0]             tail;
  logic [ROB_ID_WIDTH:0]               count;
  logic [ROB_ID_WIDTH:0]               count_nxt;
  rob_state_e                          state    [ROB_SIZE];
  logic [OP_WIDTH-1:0]                 type_q   [ROB_SIZE];
  logic [4:0]                          rd_q     [ROB_SIZE];
  logic [ADDR_WIDTH-1:0]               pc_q     [ROB_SIZE];
  logic [ADDR_WIDTH-1:0]               target_q [ROB_SIZE];
  logic [ROB_SIZE-1:0][VAL_WIDTH-1:0]  val_q;
  logic [ROB_SIZE-1:0]                 jump_q;
  logic [ROB_SIZE-1:0]                 done_vec;
  logic [ROB_SIZE-1:0]                 rs_hit;
  logic [ROB_SIZE-1:0]                 lsb_hit;
  logic [ROB_ID_WIDTH:0]               head_tag;
  logic                                do_issue;
  logic                                do_commit;
  logic                                do_flush;
  logic                                unused_pc;

  assign isFull    = count == TW'(ROB_SIZE);
  assign newTag    = TW'(tail) + TW'(1);
  assign head_tag  = TW'(head) + TW'(1);
  assign do_issue  = dec2rob_en && !isFull;
  assign do_commit = state[head] == ST_DONE;
  assign do_flush  = do_commit && jump_q[head];
  // pc is kept per entry for debug visibility only
  assign unused_pc = ^pc_q[head];

  // per-entry DONE flags and CDB label matches
  always_comb begin
    done_vec = '0;
    rs_hit   = '0;
    lsb_hit  = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      done_vec[i] = state[i] == ST_DONE;
      rs_hit[i]   = cdbReady && rs_cdb2lab != '0
                 && rs_cdb2lab == TW'(i + 1);
      lsb_hit[i]  = cdbReady && lsb_cdb2lab != '0
                 && lsb_cdb2lab == TW'(i + 1);
    end
  end

  // occupancy moves by issue minus commit
  always_comb begin
    count_nxt = count;
    if (do_issue && !do_commit) begin
      count_nxt = count + TW'(1);
    end else if (!do_issue && do_commit) begin
      count_nxt = count - TW'(1);
    end
  end

  // issue, completion, commit and flush
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_en    <= 1'b0;
      commit_lab   <= '0;
      commit_rd    <= '0;
      commit_val   <= '0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
      val_q        <= '0;
      jump_q       <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        state[i]    <= ST_EMPTY;
        type_q[i]   <= '0;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        target_q[i] <= '0;
      end
    end else if (!rdy_in) begin
      commit_en <= 1'b0;
      flush     <= 1'b0;
    end else begin
      commit_en <= do_commit;
      flush     <= do_flush;
      if (do_commit) begin
        commit_lab   <= head_tag;
        commit_rd    <= rd_q[head];
        commit_val   <= val_q[head];
        commit_store <= is_store(type_q[head]);
      end
      if (do_flush) begin
        flush_pc <= target_q[head];
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          state[i] <= ST_EMPTY;
        end
      end else begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          if (do_commit && ROB_ID_WIDTH'(i) == head) begin
            state[i] <= ST_EMPTY;
          end else if (do_issue
                    && ROB_ID_WIDTH'(i) == tail) begin
            state[i]    <= is_store(dec_type)
                         ? ST_DONE : ST_ISSUED;
            type_q[i]   <= dec_type;
            rd_q[i]     <= dec_rd;
            pc_q[i]     <= dec_pc;
            val_q[i]    <= '0;
            jump_q[i]   <= 1'b0;
            target_q[i] <= '0;
          end else if (state[i] == ST_ISSUED
                    && rs_hit[i]) begin
            state[i]    <= ST_DONE;
            val_q[i]    <= rs_cdb2val;
            jump_q[i]   <= rs_cdb2jump;
            target_q[i] <= rs_cdb2target;
          end else if (state[i] == ST_ISSUED
                    && lsb_hit[i]) begin
            state[i]  <= ST_DONE;
            val_q[i]  <= lsb_cdb2val;
            jump_q[i] <= 1'b0;
          end
        end
        if (do_issue) begin
          tail <= tail + ROB_ID_WIDTH'(1);
        end
        if (do_commit) begin
          head <= head + ROB_ID_WIDTH'(1);
        end
        count <= count_nxt;
      end
    end
  end

  reorder_buffer_query #(
    .ROB_SIZE     (ROB_SIZE),
    .ROB_ID_WIDTH (ROB_ID_WIDTH)
  ) u_query1 (
    .query_lab (query_lab1),
    .done      (done_vec),
    .vals      (val_q),
    .cdb_ready (cdbReady),
    .rs_lab    (rs_cdb2lab),
    .rs_val    (rs_cdb2val),
    .lsb_lab   (lsb_cdb2lab),
    .lsb_val   (lsb_cdb2val),
    .ready     (ready1),
    .res       (res1)
  );

  reorder_buffer_query #(
    .ROB_SIZE     (ROB_SIZE),
    .ROB_ID_WIDTH (ROB_ID_WIDTH)
  ) u_query2 (
    .query_lab (query_lab2),
    .done      (done_vec),
    .vals      (val_q),
    .cdb_ready (cdbReady),
    .rs_lab    (rs_cdb2lab),
    .rs_val    (rs_cdb2val),
    .lsb_lab   (lsb_cdb2lab),
    .lsb_val   (lsb_cdb2val),
    .ready     (ready2),
    .res       (res2)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order commit,
// full/wrap, bypass, dual completion, flush and reset.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dec2rob_en;
  logic [6:0]  dec_type;
  logic [4:0]  dec_rd;
  logic [31:0] dec_pc;
  logic        isFull;
  logic [3:0]  newTag;
  logic [3:0]  query_lab1;
  logic [3:0]  query_lab2;
  logic        ready1;
  logic        ready2;
  logic [31:0] res1;
  logic [31:0] res2;
  logic        cdbReady;
  logic [3:0]  rs_cdb2lab;
  logic [31:0] rs_cdb2val;
  logic        rs_cdb2jump;
  logic [31:0] rs_cdb2target;
  logic [3:0]  lsb_cdb2lab;
  logic [31:0] lsb_cdb2val;
  logic        commit_en;
  logic [3:0]  commit_lab;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic        commit_store;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .dec2rob_en    (dec2rob_en),
    .dec_type      (dec_type),
    .dec_rd        (dec_rd),
    .dec_pc        (dec_pc),
    .isFull        (isFull),
    .newTag        (newTag),
    .query_lab1    (query_lab1),
    .query_lab2    (query_lab2),
    .ready1        (ready1),
    .ready2        (ready2),
    .res1          (res1),
    .res2          (res2),
    .cdbReady      (cdbReady),
    .rs_cdb2lab    (rs_cdb2lab),
    .rs_cdb2val    (rs_cdb2val),
    .rs_cdb2jump   (rs_cdb2jump),
    .rs_cdb2target (rs_cdb2target),
    .lsb_cdb2lab   (lsb_cdb2lab),
    .lsb_cdb2val   (lsb_cdb2val),
    .commit_en     (commit_en),
    .commit_lab    (commit_lab),
    .commit_rd     (commit_rd),
    .commit_val    (commit_val),
    .commit_store  (commit_store),
    .flush         (flush),
    .flush_pc      (flush_pc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_clear();
    cdbReady      = 1'b0;
    rs_cdb2lab    = '0;
    rs_cdb2val    = '0;
    rs_cdb2jump   = 1'b0;
    rs_cdb2target = '0;
    lsb_cdb2lab   = '0;
    lsb_cdb2val   = '0;
  endtask

  task automatic issue(input logic [4:0] rd,
                       input logic [6:0] op,
                       input logic [3:0] exp_tag);
    dec2rob_en = 1'b1;
    dec_rd     = rd;
    dec_type   = op;
    dec_pc     = {25'd0, rd, 2'b00};
    #1;
    chk("issue_tag", 32'(newTag), 32'(exp_tag));
    cyc();
    dec2rob_en = 1'b0;
  endtask

  initial begin
    rst_in     = 1'b1;
    rdy_in     = 1'b1;
    dec2rob_en = 1'b0;
    dec_type   = OP_ALU;
    dec_rd     = '0;
    dec_pc     = '0;
    query_lab1 = '0;
    query_lab2 = '0;
    cdb_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", 32'(isFull), 0);
    chk("rst_tag", 32'(newTag), 1);
    chk("rst_commit", 32'(commit_en), 0);
    chk("rst_flush", 32'(flush), 0);
    rst_in = 1'b0;

    // in-order commit with out-of-order completion
    for (int i = 1; i <= 3; i++) begin
      issue(5'(i), OP_ALU, 4'(i));
    end
    cdbReady = 1'b1;
    rs_cdb2lab = 4'd2; rs_cdb2val = 32'h22;
    cyc();
    rs_cdb2lab = 4'd1; rs_cdb2val = 32'h11;
    cyc();
    chk("ooo_nocommit", 32'(commit_en), 0);
    rs_cdb2lab = 4'd3; rs_cdb2val = 32'h33;
    cyc();
    cdb_clear();
    chk("c1_en", 32'(commit_en), 1);
    chk("c1_lab", 32'(commit_lab), 1);
    chk("c1_rd", 32'(commit_rd), 1);
    chk("c1_val", commit_val, 32'h11);
    cyc();
    chk("c2_lab", 32'(commit_lab), 2);
    chk("c2_val", commit_val, 32'h22);
    cyc();
    chk("c3_lab", 32'(commit_lab), 3);
    chk("c3_val", commit_val, 32'h33);
    chk("c3_store", 32'(commit_store), 0);
    cyc();
    chk("c_idle", 32'(commit_en), 0);
    chk("c_tag4", 32'(newTag), 4);

    // fill to full, wrap tag 1 on commit+issue
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      issue(5'(i), OP_ALU, 4'(i));
    end
    chk("full", 32'(isFull), 1);
    chk("full_tag", 32'(newTag), 1);
    dec2rob_en = 1'b1;
    dec_rd     = 5'd20;
    cyc();
    dec2rob_en = 1'b0;
    chk("full_hold", 32'(isFull), 1);
    cdbReady = 1'b1;
    lsb_cdb2lab = 4'd1; lsb_cdb2val = 32'hA1;
    cyc();
    cdb_clear();
    chk("w_nocommit", 32'(commit_en), 0);
    cyc();
    chk("w_en", 32'(commit_en), 1);
    chk("w_lab", 32'(commit_lab), 1);
    chk("w_rd", 32'(commit_rd), 1);
    chk("w_val", commit_val, 32'hA1);
    chk("w_noflush", 32'(flush), 0);
    chk("w_notfull", 32'(isFull), 0);
    issue(5'd9, OP_ALU, 4'd1);
    chk("w_full8", 32'(isFull), 1);
    chk("w_idle", 32'(commit_en), 0);

    // same-cycle CDB bypass and label 0
    cdbReady = 1'b1;
    rs_cdb2lab = 4'd4; rs_cdb2val = 32'h55;
    query_lab1 = 4'd4;
    query_lab2 = 4'd0;
    #1;
    chk("byp_rdy", 32'(ready1), 1);
    chk("byp_res", res1, 32'h55);
    chk("q0_rdy", 32'(ready2), 1);
    chk("q0_res", res2, 0);
    query_lab2 = 4'd5;
    #1;
    chk("q5_notrdy", 32'(ready2), 0);
    cyc();
    cdb_clear();
    #1;
    chk("q4_stored", 32'(ready1), 1);
    chk("q4_val", res1, 32'h55);

    // dual-bus completion, then rdy_in hold
    cdbReady = 1'b1;
    rs_cdb2lab  = 4'd5; rs_cdb2val  = 32'h5;
    lsb_cdb2lab = 4'd6; lsb_cdb2val = 32'h6;
    cyc();
    cdb_clear();
    query_lab1 = 4'd5;
    query_lab2 = 4'd6;
    #1;
    chk("dual_rdy5", 32'(ready1), 1);
    chk("dual_res5", res1, 32'h5);
    chk("dual_rdy6", 32'(ready2), 1);
    chk("dual_res6", res2, 32'h6);
    rdy_in   = 1'b0;
    cdbReady = 1'b1;
    rs_cdb2lab = 4'd2; rs_cdb2val = 32'h99;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_commit", 32'(commit_en), 0);
    end
    cdb_clear();
    rdy_in = 1'b1;
    query_lab1 = 4'd2;
    #1;
    chk("hold_t2", 32'(ready1), 0);
    chk("hold_full", 32'(isFull), 1);
    cyc();
    chk("hold_after", 32'(commit_en), 0);
    query_lab1 = '0;
    query_lab2 = '0;

    // jump commit flushes younger DONE entries
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    issue(5'd1, OP_ALU, 4'd1);
    issue(5'd2, OP_STORE, 4'd2);
    issue(5'd3, OP_ALU, 4'd3);
    cdbReady = 1'b1;
    rs_cdb2lab = 4'd3; rs_cdb2val = 32'h33;
    cyc();
    rs_cdb2lab    = 4'd1; rs_cdb2val = 32'h44;
    rs_cdb2jump   = 1'b1;
    rs_cdb2target = 32'h100;
    cyc();
    cdb_clear();
    dec2rob_en = 1'b1;
    dec_rd     = 5'd7;
    dec_type   = OP_ALU;
    cyc();
    dec2rob_en = 1'b0;
    chk("j_en", 32'(commit_en), 1);
    chk("j_lab", 32'(commit_lab), 1);
    chk("j_val", commit_val, 32'h44);
    chk("j_flush", 32'(flush), 1);
    chk("j_pc", flush_pc, 32'h100);
    chk("j_tag", 32'(newTag), 1);
    chk("j_notfull", 32'(isFull), 0);
    issue(5'd0, OP_STORE, 4'd1);
    chk("j_flush_off", 32'(flush), 0);
    chk("j_no_t2", 32'(commit_en), 0);
    cyc();
    chk("st_en", 32'(commit_en), 1);
    chk("st_lab", 32'(commit_lab), 1);
    chk("st_store", 32'(commit_store), 1);
    cyc();
    chk("st_idle", 32'(commit_en), 0);

    // async reset with entries in flight
    for (int i = 1; i <= 5; i++) begin
      issue(5'(10 + i), OP_ALU, 4'(i + 1));
    end
    cdbReady = 1'b1;
    rs_cdb2lab = 4'd2; rs_cdb2val = 32'h77;
    cyc();
    cdb_clear();
    cyc();
    chk("pre_rst_en", 32'(commit_en), 1);
    chk("pre_rst_lab", 32'(commit_lab), 2);
    #2;
    rst_in = 1'b1;
    #1;
    chk("ar_en", 32'(commit_en), 0);
    chk("ar_lab", 32'(commit_lab), 0);
    chk("ar_rd", 32'(commit_rd), 0);
    chk("ar_val", commit_val, 0);
    chk("ar_full", 32'(isFull), 0);
    chk("ar_tag", 32'(newTag), 1);
    #1;
    rst_in = 1'b0;
    cyc();
    issue(5'd1, OP_ALU, 4'd1);
    chk("ar_tag2", 32'(newTag), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
